// File: rtl/hir_bank_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hir_bank_mem_pkg
// Purpose : Shared definitions for the banked kernel memory: controller state
//           encoding, default parameter values and a width helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package hir_bank_mem_pkg;

  localparam int NUM_BANKS_DEF  = 16;
  localparam int DEPTH_DEF      = 16;
  localparam int DATA_W_DEF     = 32;
  localparam int RUN_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // clog2 that never returns zero, so degenerate sizes still give a legal vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hir_bank_mem_bank.sv
`default_nettype none
// ============================================================================
// Module  : hir_bank_mem_bank
// Purpose : One 1R1W memory bank, DEPTH x DATA_W. Writes commit on the rising
//           edge; the read port has a registered output that only updates on
//           rd_en, so a same-address read/write returns the old word.
// Ports   : clk, rst_n          - clock, async active-low reset (output reg only)
//           wr_en/wr_addr/wr_data - write port
//           rd_en/rd_addr        - read port
//           rd_word              - unregistered word at rd_addr (host drain path)
//           rd_data              - registered read data, holds when rd_en=0
// Revision: 1.0 - initial release
// ============================================================================
module hir_bank_mem_bank
  import hir_bank_mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rd_data
);

  // Storage is deliberately not reset so contents survive rst_n.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_word = mem_q[rd_addr];

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/hir_bank_mem.sv
`default_nettype none
// ============================================================================
// Module  : hir_bank_mem
// Purpose : Banked kernel memory with a host load/drain controller. The host
//           streams NUM_BANKS*DEPTH words in (LOAD), a one-cycle tstart opens
//           a RUN_CYCLES window during which the kernel owns every bank's
//           read and write port, then the same words stream back out (DRAIN)
//           in load order, followed by a one-cycle done pulse.
// Ports   : clk, rst_n                   - clock, async active-low reset
//           rd_addr/rd_en/rd_data        - per-bank kernel read ports
//           wr_addr/wr_en/wr_data        - per-bank kernel write ports
//           tstart                       - kernel start pulse
//           in_valid/in_ready/in_data    - host load stream
//           out_valid/out_ready/out_data - host drain stream
//           busy, done                   - controller status
// Revision: 1.0 - initial release
// ============================================================================
module hir_bank_mem
  import hir_bank_mem_pkg::*;
#(
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RUN_CYCLES = RUN_CYCLES_DEF,
  localparam int ADDR_W    = clog2_min1(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_BANKS-1:0][ADDR_W-1:0]  rd_addr,
  input  logic [NUM_BANKS-1:0]              rd_en,
  output logic [NUM_BANKS-1:0][DATA_W-1:0]  rd_data,
  input  logic [NUM_BANKS-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [NUM_BANKS-1:0]              wr_en,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]  wr_data,
  output logic                              tstart,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic                              busy,
  output logic                              done
);

  localparam int BANK_W = clog2_min1(NUM_BANKS);
  localparam int IDX_W  = ADDR_W + BANK_W;
  localparam int RUN_W  = clog2_min1(RUN_CYCLES);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BANKS * DEPTH - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Reset release qualifier: goes high on the first edge after rst_n rises,
  // so the controller can first leave IDLE on the second edge.
  // --------------------------------------------------------------------------
  logic rst_ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_ok_q <= 1'b0;
    end else begin
      rst_ok_q <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Controller state
  // --------------------------------------------------------------------------
  state_e              state_q,       state_d;
  logic [IDX_W-1:0]    idx_q,         idx_d;
  logic [RUN_W-1:0]    run_cnt_q,     run_cnt_d;
  logic                tstart_q,      tstart_d;
  logic                out_valid_q,   out_valid_d;
  logic [DATA_W-1:0]   out_data_q,    out_data_d;
  logic                done_q,        done_d;
  logic                fetched_all_q, fetched_all_d;

  logic                run_phase;
  logic                drain_phase;
  logic                host_beat;
  logic [BANK_W-1:0]   host_bank;
  logic [ADDR_W-1:0]   host_addr;
  logic [DATA_W-1:0]   host_word;

  logic [NUM_BANKS-1:0][DATA_W-1:0] bank_word;

  assign run_phase   = (state_q == ST_RUN);
  assign drain_phase = (state_q == ST_DRAIN);
  assign in_ready    = rst_ok_q && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
  assign host_beat   = in_valid && in_ready;

  // Linear host index -> (bank, word); one index register serves both LOAD
  // and DRAIN so the drain order matches the load order by construction.
  assign host_bank = BANK_W'(idx_q / IDX_W'(DEPTH));
  assign host_addr = ADDR_W'(idx_q % IDX_W'(DEPTH));
  assign host_word = bank_word[host_bank];

  // --------------------------------------------------------------------------
  // Banks: the kernel owns both ports during RUN; otherwise the host borrows
  // the write port in IDLE/LOAD and the read address during DRAIN. The bank's
  // registered read output is only clocked by kernel reads, so rd_data holds
  // outside RUN.
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic              bank_we;
    logic              bank_re;
    logic [ADDR_W-1:0] bank_waddr;
    logic [ADDR_W-1:0] bank_raddr;
    logic [DATA_W-1:0] bank_wdata;

    always_comb begin
      bank_we    = 1'b0;
      bank_waddr = wr_addr[b];
      bank_wdata = wr_data[b];
      if (run_phase) begin
        bank_we = wr_en[b];
      end else if (host_beat && (host_bank == BANK_W'(b))) begin
        bank_we    = 1'b1;
        bank_waddr = host_addr;
        bank_wdata = in_data;
      end
      bank_re    = run_phase && rd_en[b];
      bank_raddr = drain_phase ? host_addr : rd_addr[b];
    end

    hir_bank_mem_bank #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bank_we),
      .wr_addr (bank_waddr),
      .wr_data (bank_wdata),
      .rd_en   (bank_re),
      .rd_addr (bank_raddr),
      .rd_word (bank_word[b]),
      .rd_data (rd_data[b])
    );
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    run_cnt_d     = run_cnt_q;
    tstart_d      = 1'b0;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    done_d        = 1'b0;
    fetched_all_d = fetched_all_q;

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (host_beat) begin
          if (idx_q == IDX_LAST) begin
            state_d  = ST_START;
            idx_d    = '0;
            tstart_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end

      ST_START: begin
        state_d   = ST_RUN;
        run_cnt_d = '0;
      end

      ST_RUN: begin
        if (run_cnt_q == RUN_LAST) begin
          state_d       = ST_DRAIN;
          idx_d         = '0;
          fetched_all_d = 1'b0;
          out_valid_d   = 1'b0;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end

      ST_DRAIN: begin
        // The output register refills whenever it is empty or being accepted,
        // giving one word per cycle under constant out_ready.
        if (!out_valid_q || out_ready) begin
          if (!fetched_all_q) begin
            out_data_d  = host_word;
            out_valid_d = 1'b1;
            if (idx_q == IDX_LAST) begin
              fetched_all_d = 1'b1;
              idx_d         = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            // Everything fetched and the final word accepted this cycle.
            out_valid_d   = 1'b0;
            fetched_all_d = 1'b0;
            done_d        = 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      run_cnt_q     <= '0;
      tstart_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      done_q        <= 1'b0;
      fetched_all_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      run_cnt_q     <= run_cnt_d;
      tstart_q      <= tstart_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      done_q        <= done_d;
      fetched_all_q <= fetched_all_d;
    end
  end

  assign tstart    = tstart_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
